// File: rtl/vlsu_pkg.sv
// vlsu_pkg: shared constants and FSM state type for the vector load/store unit.
package vlsu_pkg;
  localparam int XLEN = 32;
  localparam int LANES_DEF = 4;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/vlsu_sequencer.sv
// vlsu_sequencer: per-lane memory access FSM, lane counter, address generator and read buffer.
module vlsu_sequencer import vlsu_pkg::*; #(
  parameter int LANES = LANES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    vector_op,
  input  logic [XLEN-1:0]         base,
  input  logic [XLEN-1:0]         stride,
  input  logic [XLEN*LANES-1:0]   wdata,
  input  logic                    dmem_ready,
  input  logic                    dmem_rvalid,
  input  logic [XLEN-1:0]         dmem_rdata,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [XLEN-1:0]         dmem_addr,
  output logic [XLEN-1:0]         dmem_wdata,
  output logic                    stall,
  output logic [XLEN*LANES-1:0]   rbuf
);
  state_e state_q, state_d;
  logic [2:0] lane_q, lane_d;
  logic [XLEN*LANES-1:0] rbuf_q, rbuf_d;
  logic [XLEN-1:0] lane_wdata;
  logic start, last;
  assign start = mem_read | mem_write;
  assign last = ~vector_op | (lane_q == 3'(LANES-1));
  always_comb begin
    lane_wdata = '0;
    for (int i = 0; i < LANES; i++) if (lane_q == 3'(i)) lane_wdata = wdata[i*XLEN +: XLEN];
  end
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    rbuf_d = rbuf_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ISSUE;
        rbuf_d = '0;
      end
      S_ISSUE: if (dmem_ready) begin
        state_d = ~mem_write ? S_WAIT : last ? S_DONE : S_ISSUE;
        lane_d = (mem_write & ~last) ? lane_q + 3'd1 : lane_q;
      end
      S_WAIT: if (dmem_rvalid) begin
        for (int i = 0; i < LANES; i++) if (lane_q == 3'(i)) rbuf_d[i*XLEN +: XLEN] = dmem_rdata;
        state_d = last ? S_DONE : S_ISSUE;
        lane_d = last ? lane_q : lane_q + 3'd1;
      end
      default: begin
        state_d = S_IDLE;
        lane_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lane_q <= '0;
      rbuf_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      rbuf_q <= rbuf_d;
    end
  end
  assign dmem_req = state_q == S_ISSUE;
  assign dmem_we = dmem_req & mem_write;
  assign dmem_addr = base + 32'(lane_q) * stride;
  assign dmem_wdata = dmem_req ? lane_wdata : '0;
  assign stall = (state_q == S_IDLE & start) | state_q == S_ISSUE | state_q == S_WAIT;
  assign rbuf = rbuf_q;
endmodule

// File: rtl/stage_memory_vlsu.sv
// stage_memory_vlsu: memory pipeline stage with lane-serial vector load/store and MEM->WB register.
// Define VLSU_STRIDE_EN to add the mem_stride port (otherwise lane stride is fixed at 4 bytes).
module stage_memory_vlsu import vlsu_pkg::*; #(
  parameter int LANES = LANES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_clear,
  input  logic                  wb_stall,
  input  logic [31:0]           mem_instr,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_write,
  input  logic                  mem_mem_read,
  input  logic                  mem_vector_op,
  input  logic [1:0]            mem_result_src,
  input  logic [32*LANES-1:0]   mem_alu_result,
  input  logic [32*LANES-1:0]   mem_write_data,
  input  logic [32*LANES-1:0]   mem_imm_ext,
  input  logic [31:0]           mem_pc_plus_4,
  input  logic [4:0]            mem_rd,
`ifdef VLSU_STRIDE_EN
  input  logic [31:0]           mem_stride,
`endif
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata,
  output logic                  mem_stall_all,
  output logic [31:0]           wb_instr,
  output logic [31:0]           wb_pc_plus_4,
  output logic                  wb_reg_write,
  output logic                  wb_vector_op,
  output logic [1:0]            wb_result_src,
  output logic [32*LANES-1:0]   wb_alu_result,
  output logic [32*LANES-1:0]   wb_read_result,
  output logic [32*LANES-1:0]   wb_imm_ext,
  output logic [4:0]            wb_rd
);
  localparam int VW = XLEN*LANES;
  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic          reg_write;
    logic          vector_op;
    logic [1:0]    result_src;
    logic [VW-1:0] alu;
    logic [VW-1:0] rres;
    logic [VW-1:0] imm;
    logic [4:0]    rd;
  } wb_t;
  logic [XLEN-1:0] stride;
  logic [VW-1:0] rbuf;
  wb_t wb_q, wb_d, wb_in, wb_clr;
`ifdef VLSU_STRIDE_EN
  assign stride = mem_stride;
`else
  assign stride = XLEN'(4);
`endif
  vlsu_sequencer #(.LANES(LANES)) u_seq (
    .clk(clk), .reset(reset),
    .mem_read(mem_mem_read), .mem_write(mem_mem_write), .vector_op(mem_vector_op),
    .base(mem_alu_result[XLEN-1:0]), .stride(stride), .wdata(mem_write_data),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall(mem_stall_all), .rbuf(rbuf)
  );
  always_comb begin
    wb_in = '{instr: mem_instr, pc: mem_pc_plus_4, reg_write: mem_reg_write,
              vector_op: mem_vector_op, result_src: mem_result_src, alu: mem_alu_result,
              rres: rbuf, imm: mem_imm_ext, rd: mem_rd};
    wb_clr = '0;
    wb_clr.instr = wb_q.instr;
    wb_d = wb_clear ? wb_clr : (~wb_stall & ~mem_stall_all) ? wb_in : wb_q;
  end
  always_ff @(posedge clk) wb_q <= reset ? '0 : wb_d;
  assign wb_instr = wb_q.instr;
  assign wb_pc_plus_4 = wb_q.pc;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_vector_op = wb_q.vector_op;
  assign wb_result_src = wb_q.result_src;
  assign wb_alu_result = wb_q.alu;
  assign wb_read_result = wb_q.rres;
  assign wb_imm_ext = wb_q.imm;
  assign wb_rd = wb_q.rd;
endmodule
